// File: rtl/fs_accel_bpdrain.sv
// Bypass-buffer drain: accepts result words from a valid/ready source, holds
// them in a small skid FIFO and writes them out as sequential word writes
// starting at a programmed base address. One job of word_cnt words per start.
module fs_accel_bpdrain #(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  word_cnt,
  input  logic              src_valid,
  input  logic [31:0]       src_data,
  output logic              src_ready,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q, in_cnt, out_cnt;

  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic              fifo_full, fifo_empty;

  logic              job_start, push, pop, last_pop;

  assign fifo_full  = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);

  assign job_start = (state == IDLE) && start && enb;

  // src_ready is built from registered state and enb only, so memory-side
  // backpressure never ripples combinationally back to the source.
  assign src_ready = (state == RUN) && enb && !fifo_full && (in_cnt < len_q);
  assign push      = src_valid && src_ready;

  // Memory side ignores enb so an outstanding request can always retire.
  assign mem_valid = !fifo_empty;
  assign pop       = mem_valid && mem_ready;
  assign last_pop  = pop && ((out_cnt + LEN_W'(1)) == len_q);

  // Address/data are held at zero when idle; the address wraps modulo 2^ADDR_W.
  assign mem_addr  = mem_valid ? (base_q + (ADDR_W'(out_cnt) << 2)) : '0;
  assign mem_wdata = mem_valid ? fifo_mem[rd_ptr] : '0;
  assign mem_wstrb = mem_valid ? 4'hF : 4'h0;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: zero-length jobs go straight to DONE; DONE lasts one cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (job_start) state_nx = (word_cnt == '0) ? DONE : RUN;
      RUN:     if (last_pop)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Job parameters and word counters; the base is forced word-aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q  <= '0;
      len_q   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (job_start) begin
      base_q  <= base_addr & ~ADDR_W'(3);
      len_q   <= word_cnt;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (push) in_cnt  <= in_cnt + LEN_W'(1);
      if (pop)  out_cnt <= out_cnt + LEN_W'(1);
    end
  end

  // FIFO pointers and occupancy; reset discards any in-flight words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= src_data;
  end

endmodule

// File: tb/tb_fs_accel_bpdrain.sv
// Randomized scoreboard bench for fs_accel_bpdrain. Each job's expected write
// stream is computed up front from the job parameters; a negedge monitor pops
// and compares on every memory handshake.
module tb_fs_accel_bpdrain;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset, enb, start;
  logic [31:0] base_addr;
  logic [15:0] word_cnt;
  logic        src_valid, src_ready;
  logic [31:0] src_data;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        busy, done;

  fs_accel_bpdrain #(.ADDR_W(32), .LEN_W(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enb(enb), .start(start),
    .base_addr(base_addr), .word_cnt(word_cnt),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int          errs = 0, checks = 0;
  int          acc_cnt = 0, wr_cnt = 0, job_len = 0;
  bit          in_job = 0;
  logic [31:0] src_words[$];
  wr_t         exp_q[$];
  wr_t         e;
  logic        prev_valid = 0, prev_ready = 0;
  logic [31:0] prev_addr = 0, prev_data = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_src_ready"}, src_ready, 0);
    chk({tag, "_mem_valid"}, mem_valid, 0);
    chk({tag, "_mem_addr"},  mem_addr,  0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_wstrb"}, mem_wstrb, 0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_done"},      done,      0);
  endtask

  task automatic fill_rand(input int n);
    src_words.delete();
    for (int i = 0; i < n; i++) src_words.push_back($urandom);
  endtask

  // Monitor: source accept accounting, request stability, write scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 0;
    end else begin
      if (!enb) chk("src_ready_while_disabled", src_ready, 0);
      if (src_valid && src_ready) begin
        chk("src_accept_within_len", in_job && (acc_cnt < job_len), 1);
        acc_cnt++;
      end
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", mem_valid, 1);
        chk("hold_addr",  mem_addr,  prev_addr);
        chk("hold_data",  mem_wdata, prev_data);
      end
      if (mem_valid && mem_ready) begin
        chk("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("mem_addr",  mem_addr,  e.addr);
          chk("mem_wdata", mem_wdata, e.data);
          chk("mem_wstrb", mem_wstrb, 4'hF);
        end
        wr_cnt++;
      end
      if (done) chk("done_after_all_writes", in_job && (exp_q.size() == 0), 1);
      prev_valid = mem_valid;
      prev_ready = mem_ready;
      prev_addr  = mem_addr;
      prev_data  = mem_wdata;
    end
  end

  // One job. The expected write list is derived from the job parameters:
  // word i goes to (base with low bits cleared) + 4*i, modulo 2^32.
  task automatic run_job(input logic [31:0] base, input int n, input int vp,
                         input int rp, input int stall, input bit gate,
                         input int rst_after, input int lat_max);
    int  cyc;
    wr_t w;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      w.addr = {base[31:2], 2'b00} + 32'(4 * i);
      w.data = src_words[i];
      exp_q.push_back(w);
    end
    acc_cnt = 0; wr_cnt = 0; job_len = n;
    @(posedge clk); #1;
    base_addr = base; word_cnt = 16'(n); enb = 1; start = 1;
    src_valid = 0; mem_ready = 0; in_job = 1;
    @(posedge clk); #1;
    start = 0;
    chk("busy_after_start", busy, 1);
    cyc = 1;
    while (!done && cyc < 400) begin
      if (rst_after >= 0 && wr_cnt >= rst_after) begin
        #3;
        reset = 1;
        #1;
        chk_outputs_zero("midjob_reset");
        exp_q.delete(); in_job = 0;
        src_valid = 0; mem_ready = 0; start = 0;
        @(posedge clk); #3;
        reset = 0;
        @(posedge clk); #1;
        chk("busy_after_reset", busy, 0);
        chk("writes_before_reset", wr_cnt, rst_after);
        return;
      end
      if (stall > 0 && cyc == stall) begin
        chk("accepts_while_stalled", acc_cnt, DEPTH);
        chk("src_ready_when_full", src_ready, 0);
      end
      src_valid = (acc_cnt < n) ? ($urandom_range(99) < vp) : ($urandom_range(2) == 0);
      src_data  = (acc_cnt < n) ? src_words[acc_cnt] : $urandom;
      mem_ready = (cyc <= stall) ? 1'b0 : ($urandom_range(99) < rp);
      enb   = 1;
      start = ($urandom_range(5) == 0);
      if (gate && cyc >= 3 && cyc <= 8) begin
        enb = 0; start = 1;
        mem_ready = (cyc != 3);
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", done, 1);
    if (done) chk("done_latency_in_bound", cyc <= lat_max, 1);
    chk("writes_complete", wr_cnt, n);
    chk("busy_in_done", busy, 1);
    start = $urandom_range(1); src_valid = 1; src_data = $urandom; mem_ready = 1; enb = 1;
    @(posedge clk); #1;
    chk("busy_after_done", busy, 0);
    chk("done_single_cycle", done, 0);
    in_job = 0; start = 0; src_valid = 0; mem_ready = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; enb = 0; start = 0; base_addr = 0; word_cnt = 0;
    src_valid = 0; src_data = 0; mem_ready = 0;
    #2;
    chk_outputs_zero("reset");
    @(posedge clk); @(posedge clk); #3;
    reset = 0;

    // start while disabled must not launch a job
    @(posedge clk); #1;
    enb = 0; start = 1; word_cnt = 5; src_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("start_ignored_when_disabled", busy, 0);
    end
    start = 0; enb = 1; src_valid = 0;

    // basic back-to-back job: writes on consecutive cycles, done at n+2
    src_words = '{32'hA0, 32'hB1, 32'hC2};
    run_job(32'h0000_1000, 3, 100, 100, 0, 0, -1, 5);

    // memory backpressure for 10 cycles fills the FIFO and stalls the source
    fill_rand(8);
    run_job(32'h0000_2000, 8, 100, 100, 10, 0, -1, 400);

    // zero-length job
    src_words.delete();
    run_job(32'h0000_3000, 0, 100, 100, 0, 0, -1, 2);

    // enable dropped mid-job with a request pending
    fill_rand(10);
    run_job(32'h0000_4000, 10, 100, 100, 0, 1, -1, 400);

    // unaligned base near the top of the address space wraps to 0
    src_words = '{32'h1111_2222, 32'h3333_4444};
    run_job(32'hFFFF_FFFE, 2, 100, 100, 0, 0, -1, 400);

    // async reset after 2 of 5 writes, then a fresh job
    fill_rand(5);
    run_job(32'h0000_5000, 5, 100, 100, 0, 0, 2, 400);
    fill_rand(4);
    run_job(32'h0000_6000, 4, 100, 100, 0, 0, -1, 6);

    // randomized jobs
    for (int j = 0; j < 10; j++) begin
      int n;
      n = $urandom_range(1, 12);
      fill_rand(n);
      run_job($urandom, n, $urandom_range(40, 100), $urandom_range(30, 100),
              0, (j % 3 == 0), -1, 400);
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
